// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between the fetch stage and the I-cache.
interface fetch_stage_if;
  logic [15:0] icache_addr;
  logic        icache_rd;
  logic [15:0] icache_instr;
  logic        icache_r;

  modport master (
    output icache_addr,
    output icache_rd,
    input  icache_instr,
    input  icache_r
  );

  modport slave (
    input  icache_addr,
    input  icache_rd,
    output icache_instr,
    output icache_r
  );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the PC, drives the I-cache request and loads the DE latches,
// inserting bubbles on cache misses and control hazards and redirecting on MEM resolution.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        icache,
  input  logic                 dep_stall,
  input  logic                 mem_stall,
  input  logic                 v_de_br_stall,
  input  logic                 v_agex_br_stall,
  input  logic                 v_mem_br_stall,
  input  logic [1:0]           mem_pcmux,
  input  logic [15:0]          target_pc,
  input  logic [15:0]          trap_pc,
  output logic [15:0]          pc,
  output logic [15:0]          de_npc,
  output logic [15:0]          de_ir,
  output logic                 de_v,
  output logic [15:0]          bubble_count
);

  logic [15:0] r_pc;
  logic [15:0] r_deNpc;
  logic [15:0] r_deIr;
  logic        r_deV;
  logic [15:0] r_bubbleCount;

  logic        w_brStall;
  logic        w_ldDe;
  logic        w_redirect;
  logic        w_ldSeq;
  logic        w_newDeV;
  logic [15:0] w_pcPlus2;
  logic [15:0] w_redirectPc;

  assign w_brStall    = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
  assign w_ldDe       = ~dep_stall & ~mem_stall;
  // Encoding 11 is reserved and behaves like "not taken".
  assign w_redirect   = v_mem_br_stall & ~mem_stall &
                        ((mem_pcmux == 2'b01) | (mem_pcmux == 2'b10));
  assign w_ldSeq      = icache.icache_r & w_ldDe & ~w_brStall;
  assign w_newDeV     = icache.icache_r & ~w_brStall;
  assign w_pcPlus2    = r_pc + 16'd2;
  assign w_redirectPc = (mem_pcmux == 2'b10) ? trap_pc : target_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_deNpc       <= 16'h0000;
      r_deIr        <= 16'h0000;
      r_deV         <= 1'b0;
      r_bubbleCount <= 16'h0000;
    end else begin
      if (w_redirect) begin
        r_pc <= w_redirectPc;
      end else if (w_ldSeq) begin
        r_pc <= w_pcPlus2;
      end

      // DE payload is loaded even for bubbles so its contents stay deterministic.
      if (w_ldDe) begin
        r_deNpc <= w_pcPlus2;
        r_deIr  <= icache.icache_instr;
        r_deV   <= w_newDeV;
        if (!w_newDeV && (r_bubbleCount != 16'hFFFF)) begin
          r_bubbleCount <= r_bubbleCount + 16'd1;
        end
      end
    end
  end

  assign icache.icache_addr = r_pc;
  assign icache.icache_rd   = ~w_brStall & ~reset;

  assign pc           = r_pc;
  assign de_npc       = r_deNpc;
  assign de_ir        = r_deIr;
  assign de_v         = r_deV;
  assign bubble_count = r_bubbleCount;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: each step pushes its expected DE/PC state,
// which is popped and asserted against the DUT one cycle later.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        dep_stall;
  logic        mem_stall;
  logic        v_de_br_stall;
  logic        v_agex_br_stall;
  logic        v_mem_br_stall;
  logic [1:0]  mem_pcmux;
  logic [15:0] target_pc;
  logic [15:0] trap_pc;
  logic [15:0] pc;
  logic [15:0] de_npc;
  logic [15:0] de_ir;
  logic        de_v;
  logic [15:0] bubble_count;

  fetch_stage_if ifc ();

  fetch_stage #(.RESET_PC(16'h3000)) dut (
    .clk             (clk),
    .reset           (reset),
    .icache          (ifc.master),
    .dep_stall       (dep_stall),
    .mem_stall       (mem_stall),
    .v_de_br_stall   (v_de_br_stall),
    .v_agex_br_stall (v_agex_br_stall),
    .v_mem_br_stall  (v_mem_br_stall),
    .mem_pcmux       (mem_pcmux),
    .target_pc       (target_pc),
    .trap_pc         (trap_pc),
    .pc              (pc),
    .de_npc          (de_npc),
    .de_ir           (de_ir),
    .de_v            (de_v),
    .bubble_count    (bubble_count)
  );

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        v;
    logic [15:0] bc;
    bit          chkDe;
    logic [15:0] ir;
    logic [15:0] npc;
  } expect_t;

  expect_t scoreboard[$];
  int nChecks = 0;
  int nFail   = 0;

  // Small program image; everything else returns an address-derived pattern.
  function automatic logic [15:0] instrAt(input logic [15:0] a);
    case (a)
      16'h3000: instrAt = 16'h1261;
      16'h3002: instrAt = 16'h1482;
      16'h3004: instrAt = 16'h5000;
      default:  instrAt = a ^ 16'h5A5A;
    endcase
  endfunction

  always_comb ifc.icache_instr = instrAt(ifc.icache_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nFail++;
      $error("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    expect_t e;
    if (scoreboard.size() == 0) begin
      nChecks++;
      nFail++;
      $error("[TB] FAIL scoreboard_empty got 0 entries expected 1");
      return;
    end
    e = scoreboard.pop_front();
    checkValue({e.tag, ".pc"}, pc, e.pc);
    checkValue({e.tag, ".de_v"}, {15'd0, de_v}, {15'd0, e.v});
    checkValue({e.tag, ".bubbles"}, bubble_count, e.bc);
    if (e.chkDe) begin
      checkValue({e.tag, ".de_ir"}, de_ir, e.ir);
      checkValue({e.tag, ".de_npc"}, de_npc, e.npc);
    end
  endtask

  task automatic checkComb(input string tag, input logic expRd, input logic [15:0] expAddr);
    checkValue({tag, ".icache_rd"}, {15'd0, ifc.icache_rd}, {15'd0, expRd});
    checkValue({tag, ".icache_addr"}, ifc.icache_addr, expAddr);
  endtask

  // brv = {v_de, v_agex, v_mem}; inputs stay applied after the step until the next call.
  task automatic applyStimulus(
    input string tag,
    input logic rst, input logic rdy, input logic dep, input logic mst,
    input logic [2:0] brv, input logic [1:0] mux,
    input logic [15:0] tgt, input logic [15:0] trp,
    input logic [15:0] ePc, input logic eV, input logic [15:0] eBc,
    input bit chk, input logic [15:0] eIr, input logic [15:0] eNpc
  );
    expect_t e;
    reset           = rst;
    ifc.icache_r    = rdy;
    dep_stall       = dep;
    mem_stall       = mst;
    v_de_br_stall   = brv[2];
    v_agex_br_stall = brv[1];
    v_mem_br_stall  = brv[0];
    mem_pcmux       = mux;
    target_pc       = tgt;
    trap_pc         = trp;
    e.tag = tag; e.pc = ePc; e.v = eV; e.bc = eBc; e.chkDe = chk; e.ir = eIr; e.npc = eNpc;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; ifc.icache_r = 1'b0; dep_stall = 1'b0; mem_stall = 1'b0;
    v_de_br_stall = 1'b0; v_agex_br_stall = 1'b0; v_mem_br_stall = 1'b0;
    mem_pcmux = 2'b00; target_pc = 16'h0000; trap_pc = 16'h0000;

    // Reset and sequential fetch
    applyStimulus("reset", 1, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3000, 0, 16'd0, 1, 16'h0000, 16'h0000);
    checkComb("reset", 1'b0, 16'h3000);
    applyStimulus("seq0", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3002, 1, 16'd0, 1, 16'h1261, 16'h3002);
    checkComb("seq0", 1'b1, 16'h3002);
    applyStimulus("seq1", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3004, 1, 16'd0, 1, 16'h1482, 16'h3004);

    // Dependence stall freezes everything
    for (int i = 0; i < 3; i++)
      applyStimulus("dep", 0, 1, 1, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3004, 1, 16'd0, 1, 16'h1482, 16'h3004);

    // Cache miss for two cycles, then fill
    applyStimulus("miss0", 0, 0, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3004, 0, 16'd1, 0, 16'h0, 16'h0);
    applyStimulus("miss1", 0, 0, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3004, 0, 16'd2, 0, 16'h0, 16'h0);
    applyStimulus("fill", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3006, 1, 16'd2, 1, 16'h5000, 16'h3006);

    // Taken branch: three bubbles, redirect to 0x4000
    applyStimulus("brfetch", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3008, 1, 16'd2, 1, instrAt(16'h3006), 16'h3008);
    applyStimulus("br_de", 0, 1, 0, 0, 3'b100, 2'b00, 16'h0, 16'h0, 16'h3008, 0, 16'd3, 0, 16'h0, 16'h0);
    checkComb("br_de", 1'b0, 16'h3008);
    applyStimulus("br_agex", 0, 1, 0, 0, 3'b010, 2'b00, 16'h0, 16'h0, 16'h3008, 0, 16'd4, 0, 16'h0, 16'h0);
    applyStimulus("br_mem", 0, 1, 0, 0, 3'b001, 2'b01, 16'h4000, 16'h0, 16'h4000, 0, 16'd5, 0, 16'h0, 16'h0);
    applyStimulus("target", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h4002, 1, 16'd5, 1, instrAt(16'h4000), 16'h4002);

    // TRAP vector
    applyStimulus("trap", 0, 1, 0, 0, 3'b001, 2'b10, 16'h4000, 16'h0200, 16'h0200, 0, 16'd6, 0, 16'h0, 16'h0);

    // Not-taken branch at 0x3010 and the reserved select
    applyStimulus("to3010", 0, 1, 0, 0, 3'b001, 2'b01, 16'h3010, 16'h0, 16'h3010, 0, 16'd7, 0, 16'h0, 16'h0);
    applyStimulus("nt_fetch", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3012, 1, 16'd7, 1, instrAt(16'h3010), 16'h3012);
    applyStimulus("nt_de", 0, 1, 0, 0, 3'b100, 2'b00, 16'h0, 16'h0, 16'h3012, 0, 16'd8, 0, 16'h0, 16'h0);
    applyStimulus("nt_agex", 0, 1, 0, 0, 3'b010, 2'b00, 16'h0, 16'h0, 16'h3012, 0, 16'd9, 0, 16'h0, 16'h0);
    applyStimulus("nt_mem", 0, 1, 0, 0, 3'b001, 2'b00, 16'h5555, 16'h0200, 16'h3012, 0, 16'd10, 0, 16'h0, 16'h0);
    applyStimulus("nt_resume", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3014, 1, 16'd10, 1, instrAt(16'h3012), 16'h3014);
    applyStimulus("mux11", 0, 1, 0, 0, 3'b001, 2'b11, 16'h5555, 16'h0200, 16'h3014, 0, 16'd11, 0, 16'h0, 16'h0);
    applyStimulus("mux11_res", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3016, 1, 16'd11, 1, instrAt(16'h3014), 16'h3016);

    // Redirect interactions with stalls and misses
    applyStimulus("rd_mstall", 0, 1, 0, 1, 3'b001, 2'b01, 16'h4444, 16'h0, 16'h3016, 1, 16'd11, 1, instrAt(16'h3014), 16'h3016);
    applyStimulus("rd_dep", 0, 1, 1, 0, 3'b001, 2'b01, 16'h4444, 16'h0, 16'h4444, 1, 16'd11, 1, instrAt(16'h3014), 16'h3016);
    applyStimulus("rd_miss", 0, 0, 0, 0, 3'b001, 2'b01, 16'h6000, 16'h0, 16'h6000, 0, 16'd12, 0, 16'h0, 16'h0);

    // PC wrap at 0xFFFE
    applyStimulus("to_fffe", 0, 1, 0, 0, 3'b001, 2'b01, 16'hFFFE, 16'h0, 16'hFFFE, 0, 16'd13, 0, 16'h0, 16'h0);
    applyStimulus("wrap", 0, 1, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h0000, 1, 16'd13, 1, instrAt(16'hFFFE), 16'h0000);

    // Reset wins over a simultaneous redirect
    applyStimulus("rst_redir", 1, 1, 0, 0, 3'b001, 2'b01, 16'h4000, 16'h0, 16'h3000, 0, 16'd0, 1, 16'h0000, 16'h0000);

    // Bubble counter saturation
    applyStimulus("sat_first", 0, 0, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3000, 0, 16'd1, 0, 16'h0, 16'h0);
    repeat (65533) @(posedge clk);
    #1;
    applyStimulus("sat_hit", 0, 0, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3000, 0, 16'hFFFF, 0, 16'h0, 16'h0);
    applyStimulus("sat_hold", 0, 0, 0, 0, 3'b000, 2'b00, 16'h0, 16'h0, 16'h3000, 0, 16'hFFFF, 0, 16'h0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
